// File: rtl/id_ex_stage_if.sv
// ID/EX stage bundle: ID-side operands/control, live MEM/WB forward taps, and EX-side outputs.
interface id_ex_stage_if #(
  parameter int WIDTH = 32,
  parameter int AW    = 5,
  parameter int OPW   = 4
);
  logic             stall;
  logic             id_valid;
  logic [WIDTH-1:0] id_pc;
  logic [AW-1:0]    id_rs_addr;
  logic [AW-1:0]    id_rt_addr;
  logic [WIDTH-1:0] id_rs_data;
  logic [WIDTH-1:0] id_rt_data;
  logic [WIDTH-1:0] id_imm;
  logic             id_alu_src;
  logic [OPW-1:0]   id_alu_op;
  logic             id_reg_write;
  logic [AW-1:0]    id_wr_addr;
  logic [1:0]       id_tnew;
  logic             mem_fwd_en;
  logic [AW-1:0]    mem_fwd_addr;
  logic [WIDTH-1:0] mem_fwd_data;
  logic             wb_fwd_en;
  logic [AW-1:0]    wb_fwd_addr;
  logic [WIDTH-1:0] wb_fwd_data;
  logic             ex_valid;
  logic [WIDTH-1:0] ex_pc;
  logic [WIDTH-1:0] ex_alu_a;
  logic [WIDTH-1:0] ex_alu_b;
  logic [WIDTH-1:0] ex_rt_fwd;
  logic [OPW-1:0]   ex_alu_op;
  logic             ex_reg_write;
  logic [AW-1:0]    ex_wr_addr;
  logic [AW-1:0]    ex_rs_addr;
  logic [AW-1:0]    ex_rt_addr;
  logic [1:0]       ex_tnew;

  modport master (
    output stall, id_valid, id_pc, id_rs_addr, id_rt_addr, id_rs_data, id_rt_data, id_imm,
           id_alu_src, id_alu_op, id_reg_write, id_wr_addr, id_tnew,
           mem_fwd_en, mem_fwd_addr, mem_fwd_data, wb_fwd_en, wb_fwd_addr, wb_fwd_data,
    input  ex_valid, ex_pc, ex_alu_a, ex_alu_b, ex_rt_fwd, ex_alu_op, ex_reg_write,
           ex_wr_addr, ex_rs_addr, ex_rt_addr, ex_tnew
  );

  modport slave (
    input  stall, id_valid, id_pc, id_rs_addr, id_rt_addr, id_rs_data, id_rt_data, id_imm,
           id_alu_src, id_alu_op, id_reg_write, id_wr_addr, id_tnew,
           mem_fwd_en, mem_fwd_addr, mem_fwd_data, wb_fwd_en, wb_fwd_addr, wb_fwd_data,
    output ex_valid, ex_pc, ex_alu_a, ex_alu_b, ex_rt_fwd, ex_alu_op, ex_reg_write,
           ex_wr_addr, ex_rs_addr, ex_rt_addr, ex_tnew
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX-side operand forwarding (MEM over WB, $0 hardwired to zero).
module id_ex_stage #(
  parameter int WIDTH = 32,
  parameter int AW    = 5,
  parameter int OPW   = 4
) (
  input logic           clk,
  input logic           reset,
  id_ex_stage_if.slave  bus
);

  logic             vld_p1;
  logic [WIDTH-1:0] pc_p1;
  logic [AW-1:0]    rs_addr_p1;
  logic [AW-1:0]    rt_addr_p1;
  logic [WIDTH-1:0] rs_data_p1;
  logic [WIDTH-1:0] rt_data_p1;
  logic [WIDTH-1:0] imm_p1;
  logic             alu_src_p1;
  logic [OPW-1:0]   alu_op_p1;
  logic             reg_write_p1;
  logic [AW-1:0]    wr_addr_p1;
  logic [1:0]       tnew_p1;

  logic [WIDTH-1:0] fwd_rs;
  logic [WIDTH-1:0] fwd_rt;

  function automatic logic [1:0] sat_dec(input logic [1:0] t);
    return (t == 2'd0) ? 2'd0 : t - 2'd1;
  endfunction

  function automatic logic [WIDTH-1:0] fwd_sel(
    input logic [AW-1:0]    addr,
    input logic [WIDTH-1:0] grf,
    input logic             mem_en,
    input logic [AW-1:0]    mem_addr,
    input logic [WIDTH-1:0] mem_data,
    input logic             wb_en,
    input logic [AW-1:0]    wb_addr,
    input logic [WIDTH-1:0] wb_data
  );
    if (addr == '0)                          return '0;
    else if (mem_en && (mem_addr == addr))   return mem_data;
    else if (wb_en && (wb_addr == addr))     return wb_data;
    else                                     return grf;
  endfunction

  // ---- ID -> EX register: bubble on reset or stall ----
  always_ff @(posedge clk) begin
    if (reset || bus.stall) begin
      vld_p1       <= 1'b0;
      pc_p1        <= '0;
      rs_addr_p1   <= '0;
      rt_addr_p1   <= '0;
      rs_data_p1   <= '0;
      rt_data_p1   <= '0;
      imm_p1       <= '0;
      alu_src_p1   <= 1'b0;
      alu_op_p1    <= '0;
      reg_write_p1 <= 1'b0;
      wr_addr_p1   <= '0;
      tnew_p1      <= 2'd0;
    end else begin
      vld_p1       <= bus.id_valid;
      pc_p1        <= bus.id_pc;
      rs_addr_p1   <= bus.id_rs_addr;
      rt_addr_p1   <= bus.id_rt_addr;
      rs_data_p1   <= bus.id_rs_data;
      rt_data_p1   <= bus.id_rt_data;
      imm_p1       <= bus.id_imm;
      alu_src_p1   <= bus.id_alu_src;
      alu_op_p1    <= bus.id_alu_op;
      reg_write_p1 <= bus.id_reg_write & bus.id_valid;
      wr_addr_p1   <= bus.id_wr_addr;
      tnew_p1      <= bus.id_tnew;
    end
  end

  // ---- EX: forwarding muxes against live MEM/WB taps ----
  always_comb begin
    fwd_rs = fwd_sel(rs_addr_p1, rs_data_p1, bus.mem_fwd_en, bus.mem_fwd_addr, bus.mem_fwd_data,
                     bus.wb_fwd_en, bus.wb_fwd_addr, bus.wb_fwd_data);
    fwd_rt = fwd_sel(rt_addr_p1, rt_data_p1, bus.mem_fwd_en, bus.mem_fwd_addr, bus.mem_fwd_data,
                     bus.wb_fwd_en, bus.wb_fwd_addr, bus.wb_fwd_data);
  end

  assign bus.ex_valid     = vld_p1;
  assign bus.ex_pc        = pc_p1;
  assign bus.ex_alu_a     = fwd_rs;
  assign bus.ex_alu_b     = alu_src_p1 ? imm_p1 : fwd_rt;
  assign bus.ex_rt_fwd    = fwd_rt;
  assign bus.ex_alu_op    = alu_op_p1;
  assign bus.ex_reg_write = reg_write_p1;
  assign bus.ex_wr_addr   = wr_addr_p1;
  assign bus.ex_rs_addr   = rs_addr_p1;
  assign bus.ex_rt_addr   = rt_addr_p1;
  assign bus.ex_tnew      = sat_dec(tnew_p1);

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: directed vectors push hand-computed EX results; a monitor pops and checks.
module tb_id_ex_stage;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  id_ex_stage_if #(.WIDTH(32), .AW(5), .OPW(4)) bus ();

  id_ex_stage #(.WIDTH(32), .AW(5), .OPW(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    int          due;
    int          idx;
    logic        val;
    logic [31:0] pc, a, b, rtf;
    logic [3:0]  op;
    logic        rw;
    logic [4:0]  wr, rsa, rta;
    logic [1:0]  tnew;
  } exp_t;

  typedef struct {
    logic        rst, stl, val;
    logic [31:0] pc, rsd, rtd, imm;
    logic [4:0]  rsa, rta, wr;
    logic        src, rw;
    logic [3:0]  op;
    logic [1:0]  tnew;
    logic        me, we;
    logic [4:0]  ma, wa;
    logic [31:0] md, wd;
    exp_t        e;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[$];

  task automatic chk(input int idx, input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL v%0d %s: got %h required %h", idx, nm, act, req);
    end
  endtask

  function automatic vec_t vdef();
    vec_t v;
    v.rst = 0; v.stl = 0; v.val = 0; v.pc = 0; v.rsd = 0; v.rtd = 0; v.imm = 0;
    v.rsa = 0; v.rta = 0; v.wr = 0; v.src = 0; v.rw = 0; v.op = 0; v.tnew = 0;
    v.me = 0; v.we = 0; v.ma = 0; v.wa = 0; v.md = 0; v.wd = 0;
    v.e.due = 0; v.e.idx = 0; v.e.val = 0; v.e.pc = 0; v.e.a = 0; v.e.b = 0; v.e.rtf = 0;
    v.e.op = 0; v.e.rw = 0; v.e.wr = 0; v.e.rsa = 0; v.e.rta = 0; v.e.tnew = 0;
    return v;
  endfunction

  task automatic drive_id(input vec_t v);
    reset            = v.rst;
    bus.stall        = v.stl;
    bus.id_valid     = v.val;
    bus.id_pc        = v.pc;
    bus.id_rs_addr   = v.rsa;
    bus.id_rt_addr   = v.rta;
    bus.id_rs_data   = v.rsd;
    bus.id_rt_data   = v.rtd;
    bus.id_imm       = v.imm;
    bus.id_alu_src   = v.src;
    bus.id_alu_op    = v.op;
    bus.id_reg_write = v.rw;
    bus.id_wr_addr   = v.wr;
    bus.id_tnew      = v.tnew;
  endtask

  task automatic drive_fwd(input vec_t v);
    bus.mem_fwd_en   = v.me;
    bus.mem_fwd_addr = v.ma;
    bus.mem_fwd_data = v.md;
    bus.wb_fwd_en    = v.we;
    bus.wb_fwd_addr  = v.wa;
    bus.wb_fwd_data  = v.wd;
  endtask

  // Monitor: compares whenever the scoreboard head is due in this cycle.
  initial begin
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].due < cyc) begin
        chk(sb[0].idx, "missed_slot", 32'(cyc), 32'(sb[0].due));
        void'(sb.pop_front());
      end
      if (sb.size() > 0 && sb[0].due == cyc) begin
        exp_t e;
        e = sb.pop_front();
        chk(e.idx, "ex_valid",     32'(bus.ex_valid),     32'(e.val));
        chk(e.idx, "ex_pc",        bus.ex_pc,             e.pc);
        chk(e.idx, "ex_alu_a",     bus.ex_alu_a,          e.a);
        chk(e.idx, "ex_alu_b",     bus.ex_alu_b,          e.b);
        chk(e.idx, "ex_rt_fwd",    bus.ex_rt_fwd,         e.rtf);
        chk(e.idx, "ex_alu_op",    32'(bus.ex_alu_op),    32'(e.op));
        chk(e.idx, "ex_reg_write", 32'(bus.ex_reg_write), 32'(e.rw));
        chk(e.idx, "ex_wr_addr",   32'(bus.ex_wr_addr),   32'(e.wr));
        chk(e.idx, "ex_rs_addr",   32'(bus.ex_rs_addr),   32'(e.rsa));
        chk(e.idx, "ex_rt_addr",   32'(bus.ex_rt_addr),   32'(e.rta));
        chk(e.idx, "ex_tnew",      32'(bus.ex_tnew),      32'(e.tnew));
      end
    end
  end

  initial begin
    vec_t v;
    vec_t idle;
    exp_t e;
    int   n;

    // v0: reset with busy ID fields and an active MEM tap -> all zeros
    v = vdef(); v.rst = 1; v.val = 1; v.pc = 32'h100; v.rsa = 3; v.rta = 4; v.rsd = 32'h11;
    v.rtd = 32'h22; v.imm = 32'h33; v.src = 1; v.op = 4'h3; v.rw = 1; v.wr = 5; v.tnew = 2;
    v.me = 1; v.ma = 3; v.md = 32'h55;
    vecs.push_back(v);
    // v1: plain capture, no forwarding
    v = vdef(); v.val = 1; v.pc = 32'h104; v.rsa = 1; v.rta = 2; v.rsd = 5; v.rtd = 7; v.op = 4'h1;
    v.rw = 1; v.wr = 3; v.tnew = 1;
    v.e.val = 1; v.e.pc = 32'h104; v.e.a = 5; v.e.b = 7; v.e.rtf = 7; v.e.op = 4'h1; v.e.rw = 1;
    v.e.wr = 3; v.e.rsa = 1; v.e.rta = 2; v.e.tnew = 0;
    vecs.push_back(v);
    // v2: MEM and WB both match rs -> MEM wins
    v = vdef(); v.val = 1; v.pc = 32'h108; v.rsa = 8; v.rta = 9; v.rsd = 32'h11; v.rtd = 32'h22;
    v.op = 4'h2; v.rw = 1; v.wr = 10; v.tnew = 2;
    v.me = 1; v.ma = 8; v.md = 32'hAAAA; v.we = 1; v.wa = 8; v.wd = 32'hBBBB;
    v.e.val = 1; v.e.pc = 32'h108; v.e.a = 32'hAAAA; v.e.b = 32'h22; v.e.rtf = 32'h22; v.e.op = 4'h2;
    v.e.rw = 1; v.e.wr = 10; v.e.rsa = 8; v.e.rta = 9; v.e.tnew = 1;
    vecs.push_back(v);
    // v3: same but MEM disabled -> WB value
    v.pc = 32'h10C; v.me = 0; v.e.pc = 32'h10C; v.e.a = 32'hBBBB;
    vecs.push_back(v);
    // v4: WB forwards rt, non-matching MEM; tnew 3 -> 2
    v = vdef(); v.val = 1; v.pc = 32'h110; v.rsa = 8; v.rta = 9; v.rsd = 32'h11; v.rtd = 32'h22;
    v.op = 4'h7; v.rw = 1; v.wr = 4; v.tnew = 3;
    v.me = 1; v.ma = 5; v.md = 32'hDD; v.we = 1; v.wa = 9; v.wd = 32'hCC;
    v.e.val = 1; v.e.pc = 32'h110; v.e.a = 32'h11; v.e.b = 32'hCC; v.e.rtf = 32'hCC; v.e.op = 4'h7;
    v.e.rw = 1; v.e.wr = 4; v.e.rsa = 8; v.e.rta = 9; v.e.tnew = 2;
    vecs.push_back(v);
    // v5: $0 reads zero despite GRF data and forward taps on $0
    v = vdef(); v.val = 1; v.pc = 32'h114; v.rsd = 32'h1234; v.rtd = 32'h5678; v.op = 4'h1;
    v.me = 1; v.ma = 0; v.md = 32'hFFFF; v.we = 1; v.wa = 0; v.wd = 32'hEEEE;
    v.e.val = 1; v.e.pc = 32'h114; v.e.op = 4'h1;
    vecs.push_back(v);
    // v6: immediate on alu_b while store data is MEM-forwarded rt
    v = vdef(); v.val = 1; v.pc = 32'h118; v.rsa = 7; v.rta = 6; v.rsd = 32'h77; v.rtd = 32'h1;
    v.imm = 32'hFFFFFFFC; v.src = 1; v.op = 4'hF; v.wr = 0; v.tnew = 0;
    v.me = 1; v.ma = 6; v.md = 32'h99;
    v.e.val = 1; v.e.pc = 32'h118; v.e.a = 32'h77; v.e.b = 32'hFFFFFFFC; v.e.rtf = 32'h99;
    v.e.op = 4'hF; v.e.rsa = 7; v.e.rta = 6;
    vecs.push_back(v);
    // v7, v8: two stall cycles with a live instruction -> two bubbles
    v = vdef(); v.stl = 1; v.val = 1; v.pc = 32'h11C; v.rsa = 3; v.rsd = 32'h44; v.rw = 1; v.wr = 3;
    v.tnew = 2; v.op = 4'h9; v.me = 1; v.ma = 0; v.md = 32'hDEAD;
    vecs.push_back(v);
    vecs.push_back(v);
    // v9: invalid instruction captured, reg_write gated off
    v = vdef(); v.val = 0; v.pc = 32'h120; v.rsa = 2; v.rsd = 32'h3; v.op = 4'h5; v.rw = 1;
    v.wr = 7; v.tnew = 1;
    v.e.val = 0; v.e.pc = 32'h120; v.e.a = 32'h3; v.e.op = 4'h5; v.e.rw = 0; v.e.wr = 7;
    v.e.rsa = 2; v.e.tnew = 0;
    vecs.push_back(v);
    // v10: stall and reset together -> reset values
    v = vdef(); v.rst = 1; v.stl = 1; v.val = 1; v.pc = 32'h124; v.rsa = 1; v.rsd = 32'h9;
    v.rw = 1; v.wr = 1; v.tnew = 3; v.op = 4'h2;
    vecs.push_back(v);
    // v11: WB forwards rs, disabled MEM tap ignored on rt
    v = vdef(); v.val = 1; v.pc = 32'h128; v.rsa = 1; v.rta = 2; v.rsd = 32'h10; v.rtd = 32'h20;
    v.op = 4'h6; v.tnew = 2; v.me = 0; v.ma = 2; v.md = 32'h40; v.we = 1; v.wa = 1; v.wd = 32'h30;
    v.e.val = 1; v.e.pc = 32'h128; v.e.a = 32'h30; v.e.b = 32'h20; v.e.rtf = 32'h20; v.e.op = 4'h6;
    v.e.rsa = 1; v.e.rta = 2; v.e.tnew = 1;
    vecs.push_back(v);

    idle = vdef();
    drive_id(idle);
    drive_fwd(idle);
    reset = 1'b1;
    repeat (2) @(posedge clk);

    n = vecs.size();
    for (int i = 0; i <= n; i++) begin
      @(posedge clk);
      #1;
      if (i > 0) begin
        drive_fwd(vecs[i-1]);
        e = vecs[i-1].e;
        e.due = cyc;
        e.idx = i - 1;
        sb.push_back(e);
      end
      if (i < n) drive_id(vecs[i]);
      else       drive_id(idle);
    end

    repeat (3) @(posedge clk);
    #1;
    chk(-1, "scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
